rx_packet_arbiter: RTL and testbench

// - Packet-level round-robin arbiter that merges two rx AXI-Stream packet FIFOs onto one master stream.
// - An input is eligible only when its external packet count is non-zero, i.e. at least one complete packet is buffered.
// - Once granted, an input owns the output until its TLAST beat; packets are never interleaved.
// - Sits between the per-port rx FIFOs (with their packet counters) and the shared DMA/readout stream.

---
 rtl/rx_packet_arbiter.sv | 141 ++++++++++++++
 tb/tb_rx_packet_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_packet_arbiter.sv
// Packet-level round-robin merge of two rx packet FIFOs onto one stream; PKT_ARB_STATS_EN adds forwarded-packet counters.
// Latency: 1-cycle grant decision, then combinational pass-through; 1 idle cycle between packets.
// Backpressure: M_AXIS_TREADY passes straight to the granted source; the other source sees TREADY=0.
module rx_packet_arbiter #(
    parameter int C_DATA_WIDTH       = 32,
    parameter int C_DATA_COUNT_WIDTH = 11,
    parameter int C_STATS_WIDTH      = 32
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [C_DATA_WIDTH-1:0]       S0_AXIS_TDATA,
    input  logic                          S0_AXIS_TVALID,
    input  logic                          S0_AXIS_TLAST,
    output logic                          S0_AXIS_TREADY,
    input  logic [C_DATA_COUNT_WIDTH-1:0] S0_PACKET_COUNT,
    input  logic [C_DATA_WIDTH-1:0]       S1_AXIS_TDATA,
    input  logic                          S1_AXIS_TVALID,
    input  logic                          S1_AXIS_TLAST,
    output logic                          S1_AXIS_TREADY,
    input  logic [C_DATA_COUNT_WIDTH-1:0] S1_PACKET_COUNT,
    output logic [C_DATA_WIDTH-1:0]       M_AXIS_TDATA,
    output logic                          M_AXIS_TVALID,
    output logic                          M_AXIS_TLAST,
    output logic                          M_AXIS_TUSER,
    input  logic                          M_AXIS_TREADY,
    input  logic                          STATS_CLEAR,
    output logic [C_STATS_WIDTH-1:0]      S0_PKT_FWD,
    output logic [C_STATS_WIDTH-1:0]      S1_PKT_FWD
);

    localparam logic [2:0] ST_IDLE   = 3'b001;
    localparam logic [2:0] ST_GRANT0 = 3'b010;
    localparam logic [2:0] ST_GRANT1 = 3'b100;

    logic [2:0] state, state_nxt;
    logic       last_grant, last_grant_nxt;
    logic       elig0, elig1;
    logic       eop0, eop1;

    assign elig0 = (S0_PACKET_COUNT != '0);
    assign elig1 = (S1_PACKET_COUNT != '0);
    assign eop0  = (state == ST_GRANT0) & S0_AXIS_TVALID & M_AXIS_TREADY & S0_AXIS_TLAST;
    assign eop1  = (state == ST_GRANT1) & S1_AXIS_TVALID & M_AXIS_TREADY & S1_AXIS_TLAST;

    // Every grant returns through IDLE so the next decision sees the post-packet count.
    always_comb begin
        state_nxt      = ST_IDLE;
        last_grant_nxt = last_grant;
        case (state)
            ST_IDLE: begin
                if (elig0 && elig1)
                    state_nxt = last_grant ? ST_GRANT0 : ST_GRANT1;
                else if (elig0)
                    state_nxt = ST_GRANT0;
                else if (elig1)
                    state_nxt = ST_GRANT1;
                else
                    state_nxt = ST_IDLE;
            end
            ST_GRANT0: begin
                if (eop0) begin
                    state_nxt      = ST_IDLE;
                    last_grant_nxt = 1'b0;
                end else begin
                    state_nxt = ST_GRANT0;
                end
            end
            ST_GRANT1: begin
                if (eop1) begin
                    state_nxt      = ST_IDLE;
                    last_grant_nxt = 1'b1;
                end else begin
                    state_nxt = ST_GRANT1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        M_AXIS_TDATA   = '0;
        M_AXIS_TVALID  = 1'b0;
        M_AXIS_TLAST   = 1'b0;
        M_AXIS_TUSER   = 1'b0;
        S0_AXIS_TREADY = 1'b0;
        S1_AXIS_TREADY = 1'b0;
        case (state)
            ST_GRANT0: begin
                M_AXIS_TDATA   = S0_AXIS_TDATA;
                M_AXIS_TVALID  = S0_AXIS_TVALID;
                M_AXIS_TLAST   = S0_AXIS_TLAST;
                M_AXIS_TUSER   = 1'b0;
                S0_AXIS_TREADY = M_AXIS_TREADY;
            end
            ST_GRANT1: begin
                M_AXIS_TDATA   = S1_AXIS_TDATA;
                M_AXIS_TVALID  = S1_AXIS_TVALID;
                M_AXIS_TLAST   = S1_AXIS_TLAST;
                M_AXIS_TUSER   = 1'b1;
                S1_AXIS_TREADY = M_AXIS_TREADY;
            end
            default: ;
        endcase
    end

`ifdef PKT_ARB_STATS_EN
    logic [C_STATS_WIDTH-1:0] fwd0, fwd1;

    // Saturating counters; a clear in the same cycle as a TLAST handshake wins.
    always_ff @(posedge aclk) begin
        if (!aresetn || STATS_CLEAR) begin
            fwd0 <= '0;
            fwd1 <= '0;
        end else begin
            if (eop0 && (fwd0 != '1))
                fwd0 <= fwd0 + C_STATS_WIDTH'(1);
            if (eop1 && (fwd1 != '1))
                fwd1 <= fwd1 + C_STATS_WIDTH'(1);
        end
    end

    assign S0_PKT_FWD = fwd0;
    assign S1_PKT_FWD = fwd1;
`else
    logic unused_stats_clear;
    assign unused_stats_clear = STATS_CLEAR;
    assign S0_PKT_FWD         = '0;
    assign S1_PKT_FWD         = '0;
`endif

endmodule

// File: tb/tb_rx_packet_arbiter.sv
// Directed bench for rx_packet_arbiter: FIFO-like source models, beat log with cycle stamps.
module tb_rx_packet_arbiter;
    localparam int DW = 32;
    localparam int CW = 11;
    localparam int SW = 4;
`ifdef PKT_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [DW-1:0] S0_AXIS_TDATA = '0, S1_AXIS_TDATA = '0, M_AXIS_TDATA;
    logic          S0_AXIS_TVALID = 1'b0, S0_AXIS_TLAST = 1'b0, S0_AXIS_TREADY;
    logic          S1_AXIS_TVALID = 1'b0, S1_AXIS_TLAST = 1'b0, S1_AXIS_TREADY;
    logic [CW-1:0] S0_PACKET_COUNT = '0, S1_PACKET_COUNT = '0;
    logic          M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TUSER;
    logic          M_AXIS_TREADY = 1'b0;
    logic          STATS_CLEAR = 1'b0;
    logic [SW-1:0] S0_PKT_FWD, S1_PKT_FWD;

    rx_packet_arbiter #(.C_DATA_WIDTH(DW), .C_DATA_COUNT_WIDTH(CW), .C_STATS_WIDTH(SW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .S0_AXIS_TDATA(S0_AXIS_TDATA), .S0_AXIS_TVALID(S0_AXIS_TVALID), .S0_AXIS_TLAST(S0_AXIS_TLAST),
        .S0_AXIS_TREADY(S0_AXIS_TREADY), .S0_PACKET_COUNT(S0_PACKET_COUNT),
        .S1_AXIS_TDATA(S1_AXIS_TDATA), .S1_AXIS_TVALID(S1_AXIS_TVALID), .S1_AXIS_TLAST(S1_AXIS_TLAST),
        .S1_AXIS_TREADY(S1_AXIS_TREADY), .S1_PACKET_COUNT(S1_PACKET_COUNT),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TLAST(M_AXIS_TLAST),
        .M_AXIS_TUSER(M_AXIS_TUSER), .M_AXIS_TREADY(M_AXIS_TREADY),
        .STATS_CLEAR(STATS_CLEAR), .S0_PKT_FWD(S0_PKT_FWD), .S1_PKT_FWD(S1_PKT_FWD)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int            cyc;
        logic          user;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic [DW:0] q0[$], q1[$];
    beat_t       outq[$];
    int          n_cmp = 0, n_bad = 0, cyc_n = 0;
    logic        smv, s0r, s1r, smlast, smuser;
    logic [DW-1:0] smdat;
    logic [SW-1:0] sf0, sf1;

    // One clock: drive from source queues at the falling edge, sample 1 ns later, pop handshaken beats.
    task automatic cyc(input logic mrdy, input logic rst_n = 1'b1, input logic clr = 1'b0);
        int   c0 = 0, c1 = 0;
        logic h0, h1;
        foreach (q0[i]) if (q0[i][DW]) c0++;
        foreach (q1[i]) if (q1[i][DW]) c1++;
        aresetn         = rst_n;
        STATS_CLEAR     = clr;
        M_AXIS_TREADY   = mrdy;
        S0_AXIS_TVALID  = (q0.size() != 0);
        S0_AXIS_TDATA   = (q0.size() != 0) ? q0[0][DW-1:0] : '0;
        S0_AXIS_TLAST   = (q0.size() != 0) && q0[0][DW];
        S0_PACKET_COUNT = CW'(c0);
        S1_AXIS_TVALID  = (q1.size() != 0);
        S1_AXIS_TDATA   = (q1.size() != 0) ? q1[0][DW-1:0] : '0;
        S1_AXIS_TLAST   = (q1.size() != 0) && q1[0][DW];
        S1_PACKET_COUNT = CW'(c1);
        #1;
        smv = M_AXIS_TVALID; smlast = M_AXIS_TLAST; smuser = M_AXIS_TUSER; smdat = M_AXIS_TDATA;
        s0r = S0_AXIS_TREADY; s1r = S1_AXIS_TREADY; sf0 = S0_PKT_FWD; sf1 = S1_PKT_FWD;
        if (M_AXIS_TVALID && M_AXIS_TREADY)
            outq.push_back('{cyc_n, M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TDATA});
        h0 = S0_AXIS_TVALID && S0_AXIS_TREADY;
        h1 = S1_AXIS_TVALID && S1_AXIS_TREADY;
        @(negedge aclk);
        cyc_n++;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else begin
            if (h0) void'(q0.pop_front());
            if (h1) void'(q1.pop_front());
        end
    endtask

    task automatic pkt(input int src, input logic [DW-1:0] d0, input int n);
        for (int i = 0; i < n; i++) begin
            logic [DW:0] b;
            b = {(i == n - 1), d0 + DW'(i)};
            if (src == 0) q0.push_back(b);
            else          q1.push_back(b);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1);
            n_cmp++;
            if (smv !== 1'b0 || s0r !== 1'b0 || s1r !== 1'b0 || smdat !== '0) begin
                n_bad++;
                $display("FAIL reset_idle cyc%0d: vld=%b s0rdy=%b s1rdy=%b dat=%h, want 0 0 0 0", i, smv, s0r, s1r, smdat);
            end
        end
        n_cmp++;
        if (sf0 !== '0 || sf1 !== '0) begin
            n_bad++;
            $display("FAIL reset_stats: fwd0=%0d fwd1=%0d, want 0 0", sf0, sf1);
        end
    endtask

    task automatic test_single();
        int t0;
        outq.delete();
        t0 = cyc_n;
        pkt(0, 32'hA0, 4);
        for (int i = 0; i < 8; i++) cyc(1'b1);
        n_cmp++;
        if (outq.size() !== 4) begin
            n_bad++;
            $display("FAIL single_count: got %0d beats, want 4", outq.size());
        end
        for (int i = 0; i < 4 && i < outq.size(); i++) begin
            n_cmp++;
            if (outq[i].data !== 32'hA0 + DW'(i) || outq[i].user !== 1'b0 ||
                outq[i].last !== (i == 3) || outq[i].cyc !== t0 + 1 + i) begin
                n_bad++;
                $display("FAIL single_beat%0d: dat=%h user=%b last=%b cyc=%0d, want %h 0 %b %0d",
                         i, outq[i].data, outq[i].user, outq[i].last, outq[i].cyc - t0,
                         32'hA0 + DW'(i), (i == 3), 1 + i);
            end
        end
        n_cmp++;
        if (smv !== 1'b0 || sf0 !== (STATS ? SW'(1) : SW'(0))) begin
            n_bad++;
            $display("FAIL single_after: vld=%b fwd0=%0d, want 0 %0d", smv, sf0, STATS ? 1 : 0);
        end
    endtask

    task automatic test_round_robin();
        int            t0;
        int            offs[8]  = '{1, 2, 4, 5, 7, 8, 10, 11};
        logic          users[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
        logic [DW-1:0] dats[8]  = '{32'hB0, 32'hB1, 32'hC0, 32'hC1, 32'hB2, 32'hB3, 32'hC2, 32'hC3};
        cyc(1'b1, 1'b0);
        outq.delete();
        t0 = cyc_n;
        pkt(0, 32'hB0, 2); pkt(0, 32'hB2, 2);
        pkt(1, 32'hC0, 2); pkt(1, 32'hC2, 2);
        for (int i = 0; i < 14; i++) cyc(1'b1);
        n_cmp++;
        if (outq.size() !== 8) begin
            n_bad++;
            $display("FAIL rr_count: got %0d beats, want 8", outq.size());
        end
        for (int i = 0; i < 8 && i < outq.size(); i++) begin
            n_cmp++;
            if (outq[i].data !== dats[i] || outq[i].user !== users[i] ||
                outq[i].last !== (i % 2 == 1) || outq[i].cyc !== t0 + offs[i]) begin
                n_bad++;
                $display("FAIL rr_beat%0d: dat=%h user=%b last=%b cyc=%0d, want %h %b %b %0d",
                         i, outq[i].data, outq[i].user, outq[i].last, outq[i].cyc - t0,
                         dats[i], users[i], (i % 2 == 1), offs[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic seen_s0r = 1'b0;
        int   grant_cycles = 0;
        outq.delete();
        q0.push_back({1'b0, 32'h5555});
        pkt(1, 32'hD0, 4);
        for (int i = 0; i < 16; i++) begin
            cyc(i[0]);
            if (s0r) seen_s0r = 1'b1;
            if (smv && smuser) grant_cycles++;
        end
        n_cmp++;
        if (outq.size() !== 4 || seen_s0r !== 1'b0 || grant_cycles !== 7) begin
            n_bad++;
            $display("FAIL bp_summary: beats=%0d s0rdy_seen=%b grant_cycles=%0d, want 4 0 7",
                     outq.size(), seen_s0r, grant_cycles);
        end
        for (int i = 0; i < 4 && i < outq.size(); i++) begin
            n_cmp++;
            if (outq[i].data !== 32'hD0 + DW'(i) || outq[i].user !== 1'b1 || outq[i].last !== (i == 3)) begin
                n_bad++;
                $display("FAIL bp_beat%0d: dat=%h user=%b last=%b, want %h 1 %b",
                         i, outq[i].data, outq[i].user, outq[i].last, 32'hD0 + DW'(i), (i == 3));
            end
        end
        q0.delete();
    endtask

    task automatic test_reset_mid();
        pkt(0, 32'hF0, 2);
        pkt(0, 32'hE0, 4);
        for (int i = 0; i < 5; i++) cyc(1'b1);
        cyc(1'b1, 1'b0);
        cyc(1'b1);
        n_cmp++;
        if (smv !== 1'b0 || smlast !== 1'b0 || smuser !== 1'b0 || smdat !== '0 ||
            s0r !== 1'b0 || s1r !== 1'b0 || sf0 !== '0 || sf1 !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: vld=%b last=%b user=%b dat=%h s0rdy=%b s1rdy=%b fwd=%0d/%0d, want all 0",
                     smv, smlast, smuser, smdat, s0r, s1r, sf0, sf1);
        end
        outq.delete();
        pkt(0, 32'h70, 1);
        pkt(1, 32'h71, 1);
        for (int i = 0; i < 6; i++) cyc(1'b1);
        n_cmp++;
        if (outq.size() !== 2 || outq[0].user !== 1'b0 || outq[0].data !== 32'h70 ||
            outq[1].user !== 1'b1 || outq[1].data !== 32'h71) begin
            n_bad++;
            $display("FAIL midreset_tiebreak: beats=%0d first user=%b dat=%h, want 2 0 00000070",
                     outq.size(), outq.size() > 0 ? outq[0].user : 1'bx, outq.size() > 0 ? outq[0].data : 'x);
        end
    endtask

    task automatic test_stats();
        outq.delete();
        for (int i = 0; i < 17; i++) pkt(0, 32'h100 + DW'(i), 1);
        for (int i = 0; i < 40; i++) cyc(1'b1);
        n_cmp++;
        if (outq.size() !== 17 || sf0 !== (STATS ? SW'(15) : SW'(0)) || sf1 !== (STATS ? SW'(1) : SW'(0))) begin
            n_bad++;
            $display("FAIL stats_sat: beats=%0d fwd0=%0d fwd1=%0d, want 17 %0d %0d",
                     outq.size(), sf0, sf1, STATS ? 15 : 0, STATS ? 1 : 0);
        end
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1);
        n_cmp++;
        if (sf0 !== '0 || sf1 !== '0) begin
            n_bad++;
            $display("FAIL stats_clear: fwd0=%0d fwd1=%0d, want 0 0", sf0, sf1);
        end
    endtask

    initial begin
        @(negedge aclk);
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
